// File: rtl/conv_tile_scheduler_if.sv
// Handshake bundle between the layer sequencer and its surrounding controllers.
//   start_in            layer start pulse (from host)
//   w_done_in           weight load complete pulse
//   c_done_in           compute pass complete pulse
//   w_start_out         weight-load start pulse
//   c_start_out         compute-pass start pulse
//   *_count             current loop-nest tuple, zero-extended to 32 bits
//   first_acc_out       current tuple opens partial-sum accumulation
//   busy_out / done_out layer in progress / layer complete pulse
// master: the side that issues start/done requests and consumes the counts.
// slave:  the scheduler itself.
interface conv_tile_scheduler_if;
  logic        start_in;
  logic        w_done_in;
  logic        c_done_in;
  logic        w_start_out;
  logic        c_start_out;
  logic [31:0] O_CH_MAC_COL_count;
  logic [31:0] I_CH_MAC_ROW_count;
  logic [31:0] W_W_count;
  logic [31:0] W_H_count;
  logic        first_acc_out;
  logic        busy_out;
  logic        done_out;

  modport master (
    output start_in, w_done_in, c_done_in,
    input  w_start_out, c_start_out,
           O_CH_MAC_COL_count, I_CH_MAC_ROW_count, W_W_count, W_H_count,
           first_acc_out, busy_out, done_out
  );

  modport slave (
    input  start_in, w_done_in, c_done_in,
    output w_start_out, c_start_out,
           O_CH_MAC_COL_count, I_CH_MAC_ROW_count, W_W_count, W_H_count,
           first_acc_out, busy_out, done_out
  );
endinterface

// File: rtl/conv_tile_scheduler.sv
// Loop-nest sequencer for one convolution layer on a MAC_ROW x MAC_COL array.
// Walks every (W_H, W_W, I_CH tile, O_CH tile) tuple, O_CH innermost. For each
// tuple it issues a weight load, waits for completion, issues a compute pass
// and waits for that, then steps the odometer.
// Ports:
//   clk   clock, all logic on posedge
//   rstn  synchronous active-low reset
//   io    conv_tile_scheduler_if.slave: start/done handshakes in, start
//         pulses, loop counts, first_acc/busy/done status out
module conv_tile_scheduler #(
  parameter int unsigned MAC_ROW           = 16,
  parameter int unsigned MAC_COL           = 16,
  parameter int unsigned OFMAP_CHANNEL_NUM = 64,
  parameter int unsigned IFMAP_CHANNEL_NUM = 32,
  parameter int unsigned WEIGHT_WIDTH      = 3,
  parameter int unsigned WEIGHT_HEIGHT     = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  conv_tile_scheduler_if.slave  io
);

  localparam int unsigned O_TILES = OFMAP_CHANNEL_NUM / MAC_COL;
  localparam int unsigned I_TILES = IFMAP_CHANNEL_NUM / MAC_ROW;

  localparam logic [31:0] O_LAST  = O_TILES - 1;
  localparam logic [31:0] I_LAST  = I_TILES - 1;
  localparam logic [31:0] WW_LAST = WEIGHT_WIDTH - 1;
  localparam logic [31:0] WH_LAST = WEIGHT_HEIGHT - 1;

  typedef enum logic [2:0] {
    IDLE,
    W_ISSUE,
    W_WAIT,
    C_ISSUE,
    C_WAIT,
    ADVANCE,
    DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] o_cnt, i_cnt, ww_cnt, wh_cnt;
  logic [31:0] o_nxt, i_nxt, ww_nxt, wh_nxt;
  logic        last_tuple;
  logic        busy_nxt;

  logic        w_start_r, c_start_r, first_acc_r, busy_r, done_r;

  assign last_tuple = (o_cnt == O_LAST) && (i_cnt == I_LAST) &&
                      (ww_cnt == WW_LAST) && (wh_cnt == WH_LAST);

  always_comb begin
    state_nxt = state;
    o_nxt     = o_cnt;
    i_nxt     = i_cnt;
    ww_nxt    = ww_cnt;
    wh_nxt    = wh_cnt;
    case (state)
      IDLE: begin
        if (io.start_in) state_nxt = W_ISSUE;
      end
      W_ISSUE: state_nxt = W_WAIT;
      W_WAIT: begin
        if (io.w_done_in) state_nxt = C_ISSUE;
      end
      C_ISSUE: state_nxt = C_WAIT;
      C_WAIT: begin
        if (io.c_done_in) state_nxt = last_tuple ? DONE : ADVANCE;
      end
      ADVANCE: begin
        // Odometer: each digit wraps at its last value and carries outward.
        state_nxt = W_ISSUE;
        if (o_cnt != O_LAST) begin
          o_nxt = o_cnt + 32'd1;
        end else begin
          o_nxt = '0;
          if (i_cnt != I_LAST) begin
            i_nxt = i_cnt + 32'd1;
          end else begin
            i_nxt = '0;
            if (ww_cnt != WW_LAST) begin
              ww_nxt = ww_cnt + 32'd1;
            end else begin
              ww_nxt = '0;
              wh_nxt = (wh_cnt != WH_LAST) ? wh_cnt + 32'd1 : '0;
            end
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        o_nxt     = '0;
        i_nxt     = '0;
        ww_nxt    = '0;
        wh_nxt    = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_nxt = state_nxt inside {W_ISSUE, W_WAIT, C_ISSUE, C_WAIT, ADVANCE};

  // Outputs are registered from the next-state/next-count values, so each
  // output register always equals the decode of the state register it sits
  // beside: same cycle-level timing as a pure Moore decode, but glitch-free.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      o_cnt       <= '0;
      i_cnt       <= '0;
      ww_cnt      <= '0;
      wh_cnt      <= '0;
      w_start_r   <= 1'b0;
      c_start_r   <= 1'b0;
      first_acc_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_cnt       <= o_nxt;
      i_cnt       <= i_nxt;
      ww_cnt      <= ww_nxt;
      wh_cnt      <= wh_nxt;
      w_start_r   <= (state_nxt == W_ISSUE);
      c_start_r   <= (state_nxt == C_ISSUE);
      done_r      <= (state_nxt == DONE);
      busy_r      <= busy_nxt;
      first_acc_r <= busy_nxt && (i_nxt == '0) && (ww_nxt == '0) && (wh_nxt == '0);
    end
  end

  assign io.w_start_out        = w_start_r;
  assign io.c_start_out        = c_start_r;
  assign io.O_CH_MAC_COL_count = o_cnt;
  assign io.I_CH_MAC_ROW_count = i_cnt;
  assign io.W_W_count          = ww_cnt;
  assign io.W_H_count          = wh_cnt;
  assign io.first_acc_out      = first_acc_r;
  assign io.busy_out           = busy_r;
  assign io.done_out           = done_r;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench for conv_tile_scheduler: default-parameter instance checked every
// cycle against a tuple-index model, plus a 1-tuple degenerate instance.
module tb_conv_tile_scheduler;

  localparam int OT    = 4;
  localparam int IT    = 2;
  localparam int KW    = 3;
  localparam int KH    = 3;
  localparam int TOTAL = OT * IT * KW * KH;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  conv_tile_scheduler_if io ();
  conv_tile_scheduler_if iob ();

  conv_tile_scheduler #(
    .MAC_ROW(16), .MAC_COL(16), .OFMAP_CHANNEL_NUM(64), .IFMAP_CHANNEL_NUM(32),
    .WEIGHT_WIDTH(3), .WEIGHT_HEIGHT(3)
  ) dut (.clk(clk), .rstn(rstn), .io(io));

  conv_tile_scheduler #(
    .MAC_ROW(16), .MAC_COL(16), .OFMAP_CHANNEL_NUM(16), .IFMAP_CHANNEL_NUM(16),
    .WEIGHT_WIDTH(1), .WEIGHT_HEIGHT(1)
  ) dutb (.clk(clk), .rstn(rstn), .io(iob));

  int n_assert = 0;
  int n_fail   = 0;

  function automatic void chk1(string nm, logic act, logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: actual %0b required %0b at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk32(string nm, logic [31:0] act, logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: actual %0d required %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: a layer is a sequence of TOTAL tuples indexed by m_t; the counts
  // follow from m_t by division/modulo. Pulse flags say what the DUT shows
  // during the cycle following each edge.
  bit m_busy = 0, m_wst = 0, m_cst = 0, m_adv = 0, m_done = 0, cmp_en = 0;
  int m_wait = 0;   // 0 none, 1 awaiting w_done, 2 awaiting c_done
  int m_t    = 0;

  always @(posedge clk) begin
    m_wst  <= 0;
    m_cst  <= 0;
    m_adv  <= 0;
    m_done <= 0;
    if (!rstn) begin
      m_busy <= 0;
      m_wait <= 0;
      m_t    <= 0;
      cmp_en <= 1;
    end else if (m_done) begin
      m_t <= 0;
    end else if (!m_busy) begin
      if (io.start_in) begin
        m_busy <= 1;
        m_wst  <= 1;
      end
    end else if (m_wst) begin
      m_wait <= 1;
    end else if (m_cst) begin
      m_wait <= 2;
    end else if (m_adv) begin
      m_t   <= m_t + 1;
      m_wst <= 1;
    end else if (m_wait == 1 && io.w_done_in) begin
      m_wait <= 0;
      m_cst  <= 1;
    end else if (m_wait == 2 && io.c_done_in) begin
      m_wait <= 0;
      if (m_t == TOTAL - 1) begin
        m_done <= 1;
        m_busy <= 0;
      end else begin
        m_adv <= 1;
      end
    end
  end

  // Pulse counters and per-tuple capture taken at each w_start pulse.
  int          cnt_w = 0, cnt_c = 0, cnt_d = 0;
  logic [31:0] cap_o [0:511];
  logic [31:0] cap_i [0:511];
  logic [31:0] cap_ww[0:511];
  logic [31:0] cap_wh[0:511];
  logic        cap_f [0:511];

  always @(negedge clk) begin
    if (io.w_start_out === 1'b1) begin
      if (cnt_w < 512) begin
        cap_o[cnt_w]  <= io.O_CH_MAC_COL_count;
        cap_i[cnt_w]  <= io.I_CH_MAC_ROW_count;
        cap_ww[cnt_w] <= io.W_W_count;
        cap_wh[cnt_w] <= io.W_H_count;
        cap_f[cnt_w]  <= io.first_acc_out;
      end
      cnt_w <= cnt_w + 1;
    end
    if (io.c_start_out === 1'b1) cnt_c <= cnt_c + 1;
    if (io.done_out === 1'b1)    cnt_d <= cnt_d + 1;
  end

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk1("w_start_out", io.w_start_out, m_wst);
        chk1("c_start_out", io.c_start_out, m_cst);
        chk1("done_out", io.done_out, m_done);
        chk1("busy_out", io.busy_out, m_busy);
        chk1("first_acc_out", io.first_acc_out, m_busy && (m_t < OT));
        chk32("O_CH_MAC_COL_count", io.O_CH_MAC_COL_count, 32'(m_t % OT));
        chk32("I_CH_MAC_ROW_count", io.I_CH_MAC_ROW_count, 32'((m_t / OT) % IT));
        chk32("W_W_count", io.W_W_count, 32'((m_t / (OT * IT)) % KW));
        chk32("W_H_count", io.W_H_count, 32'(m_t / (OT * IT * KW)));
      end
    end
  endtask

  task automatic start_layer();
    io.start_in = 1'b1;
    @(posedge clk); #1;
    io.start_in = 1'b0;
  endtask

  // mode: 0 normal, 1 spurious handshakes, 2 reset in C_WAIT, 3 reset in W_WAIT
  task automatic do_tuple(input int mode);
    bit ok;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      ok = io.w_start_out;
    end
    chk1("w_start arrives", ok, 1'b1);
    if (!ok) return;
    if (mode == 3) begin
      repeat (3) @(posedge clk);
      #1; rstn = 1'b0; io.start_in = 1'b1;
      repeat (2) @(posedge clk);
      #1; rstn = 1'b1; io.start_in = 1'b0;
      return;
    end
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      io.c_done_in = (mode == 1 && i == 3);
      io.start_in  = (mode == 1 && i == 3);
    end
    io.c_done_in = 1'b0; io.start_in = 1'b0; io.w_done_in = 1'b1;
    @(posedge clk); #1;
    io.w_done_in = 1'b0;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      ok = io.c_start_out;
    end
    chk1("c_start arrives", ok, 1'b1);
    if (!ok) return;
    if (mode == 2) begin
      repeat (5) @(posedge clk);
      #1; rstn = 1'b0; io.start_in = 1'b1;
      repeat (2) @(posedge clk);
      #1; rstn = 1'b1; io.start_in = 1'b0;
      return;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      io.w_done_in = (mode == 1 && i == 3);
      io.start_in  = (mode == 1 && i == 3);
    end
    io.w_done_in = 1'b0; io.start_in = 1'b0; io.c_done_in = 1'b1;
    @(posedge clk); #1;
    io.c_done_in = 1'b0;
  endtask

  task automatic chk_tuple(string nm, int idx, int eo, int ei, int ew, int eh);
    chk32({nm, " O"},  cap_o[idx],  32'(eo));
    chk32({nm, " I"},  cap_i[idx],  32'(ei));
    chk32({nm, " WW"}, cap_ww[idx], 32'(ew));
    chk32({nm, " WH"}, cap_wh[idx], 32'(eh));
  endtask

  task automatic check_full_layer(string nm, int bw, int bc, int bd);
    chk32({nm, " w_start pulses"}, 32'(cnt_w - bw), 32'd72);
    chk32({nm, " c_start pulses"}, 32'(cnt_c - bc), 32'd72);
    chk32({nm, " done pulses"},    32'(cnt_d - bd), 32'd1);
    chk1({nm, " busy after"}, io.busy_out, 1'b0);
    chk_tuple({nm, " #1"},  bw,      0, 0, 0, 0);
    chk_tuple({nm, " #5"},  bw + 4,  0, 1, 0, 0);
    chk_tuple({nm, " #9"},  bw + 8,  0, 0, 1, 0);
    chk_tuple({nm, " #25"}, bw + 24, 0, 0, 0, 1);
    chk_tuple({nm, " #72"}, bw + 71, 3, 1, 2, 2);
  endtask

  task automatic main_seq();
    int bw, bc, bd;
    rstn = 1'b0;
    io.start_in = 0; io.w_done_in = 0; io.c_done_in = 0;
    iob.start_in = 0; iob.w_done_in = 0; iob.c_done_in = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk1("reset busy", io.busy_out, 1'b0);
    chk32("reset O", io.O_CH_MAC_COL_count, 32'd0);
    @(posedge clk); #1;

    // Reset mid-stream with start_in held during reset.
    start_layer();
    do_tuple(0);
    do_tuple(0);
    do_tuple(3);
    repeat (3) @(negedge clk);
    chk1("post-reset busy", io.busy_out, 1'b0);
    chk1("post-reset w_start", io.w_start_out, 1'b0);
    chk32("post-reset I", io.I_CH_MAC_ROW_count, 32'd0);
    @(posedge clk); #1;

    // Full layer, spurious handshakes on the first three tuples.
    bw = cnt_w; bc = cnt_c; bd = cnt_d;
    start_layer();
    for (int k = 0; k < TOTAL; k++) do_tuple(k < 3 ? 1 : 0);
    repeat (4) @(posedge clk); #1;
    check_full_layer("layer", bw, bc, bd);
    for (int k = 1; k <= TOTAL; k++) chk1($sformatf("first_acc #%0d", k), cap_f[bw + k - 1], k <= 4);

    // Reset in C_WAIT of tuple #10, then a clean full layer.
    start_layer();
    for (int k = 0; k < 9; k++) do_tuple(0);
    do_tuple(2);
    repeat (2) @(posedge clk); #1;
    bw = cnt_w; bc = cnt_c; bd = cnt_d;
    start_layer();
    for (int k = 0; k < TOTAL; k++) do_tuple(0);
    repeat (4) @(posedge clk); #1;
    check_full_layer("restart", bw, bc, bd);

    // Degenerate instance: a single tuple.
    iob.start_in = 1'b1;
    @(negedge clk);
    chk1("B w_start before edge", iob.w_start_out, 1'b0);
    @(posedge clk); #1;
    iob.start_in = 1'b0;
    @(negedge clk);
    chk1("B w_start", iob.w_start_out, 1'b1);
    chk1("B busy", iob.busy_out, 1'b1);
    chk1("B first_acc", iob.first_acc_out, 1'b1);
    chk32("B O", iob.O_CH_MAC_COL_count, 32'd0);
    @(posedge clk); #1;
    iob.w_done_in = 1'b1;
    @(posedge clk); #1;
    iob.w_done_in = 1'b0;
    @(negedge clk);
    chk1("B c_start", iob.c_start_out, 1'b1);
    @(posedge clk); #1;
    iob.c_done_in = 1'b1;
    @(negedge clk);
    chk1("B done before c_done edge", iob.done_out, 1'b0);
    @(posedge clk); #1;
    iob.c_done_in = 1'b0;
    @(negedge clk);
    chk1("B done", iob.done_out, 1'b1);
    chk1("B busy in done", iob.busy_out, 1'b0);
    @(negedge clk);
    chk1("B done one cycle", iob.done_out, 1'b0);
    chk1("B busy after", iob.busy_out, 1'b0);
  endtask

  initial begin
    fork
      compare_loop();
      main_seq();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
